mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 83 ++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory between the fetch port and the data port.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed D-over-I priority.
module mem_arbiter #(
    parameter int data_size = 32,
    parameter int mem_size  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IM_req,
    input  logic [mem_size-1:0]  IM_Address,
    output logic [data_size-1:0] Instruction,
    output logic                 IM_ready,
    input  logic                 DM_read,
    input  logic                 DM_enable,
    input  logic [mem_size-1:0]  DM_Address,
    input  logic [data_size-1:0] DM_Write_Data,
    output logic [data_size-1:0] DM_Read_Data,
    output logic                 DM_ready,
    output logic                 Stall,
    output logic                 MEM_req,
    output logic                 MEM_enable,
    output logic [mem_size-1:0]  MEM_Address,
    output logic [data_size-1:0] MEM_Write_Data,
    input  logic [data_size-1:0] MEM_Read_Data
);
    typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_t;
    state_t               r_state;
    logic                 r_d_wr;
    logic [data_size-1:0] r_instr;
    logic [data_size-1:0] r_dm_rd;
    logic                 w_dm_req;
    logic                 w_i_elig;
    logic                 w_d_elig;
    logic                 w_grant_i;
    logic                 w_grant_d;
    logic                 w_d_store;

    // The owner of the response in flight sits out this cycle, forcing alternation.
    assign w_dm_req = DM_read | DM_enable;
    assign w_i_elig = ~rst & IM_req & (r_state != RESP_I);
    assign w_d_elig = ~rst & w_dm_req & (r_state != RESP_D);
`ifdef MEM_ARB_RR_EN
    logic r_last_d;
    assign w_grant_d = w_d_elig & (~w_i_elig | ~r_last_d);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last_d <= 1'b1;
        else if (MEM_req)
            r_last_d <= w_grant_d;
    end
`else
    assign w_grant_d = w_d_elig;
`endif
    assign w_grant_i = w_i_elig & ~w_grant_d;
    assign w_d_store = w_grant_d & DM_enable;

    assign MEM_req        = w_grant_i | w_grant_d;
    assign MEM_enable     = w_d_store;
    assign MEM_Address    = w_grant_d ? DM_Address : (w_grant_i ? IM_Address : '0);
    assign MEM_Write_Data = w_d_store ? DM_Write_Data : '0;

    assign IM_ready     = r_state == RESP_I;
    assign DM_ready     = r_state == RESP_D;
    assign Instruction  = IM_ready ? MEM_Read_Data : r_instr;
    assign DM_Read_Data = (DM_ready & ~r_d_wr) ? MEM_Read_Data : r_dm_rd;
    assign Stall        = (IM_req & ~IM_ready) | (w_dm_req & ~DM_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_d_wr  <= 1'b0;
            r_instr <= '0;
            r_dm_rd <= '0;
        end else begin
            r_state <= w_grant_d ? RESP_D : (w_grant_i ? RESP_I : IDLE);
            r_d_wr  <= w_d_store;
            if (IM_ready)
                r_instr <= MEM_Read_Data;
            if (DM_ready & ~r_d_wr)
                r_dm_rd <= MEM_Read_Data;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a behavioural sync-read memory.
module tb_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 16;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          IM_req = 1'b0;
    logic [AW-1:0] IM_Address = '0;
    logic [DW-1:0] Instruction;
    logic          IM_ready;
    logic          DM_read = 1'b0;
    logic          DM_enable = 1'b0;
    logic [AW-1:0] DM_Address = '0;
    logic [DW-1:0] DM_Write_Data = '0;
    logic [DW-1:0] DM_Read_Data;
    logic          DM_ready;
    logic          Stall;
    logic          MEM_req;
    logic          MEM_enable;
    logic [AW-1:0] MEM_Address;
    logic [DW-1:0] MEM_Write_Data;
    logic [DW-1:0] mem_rd = '0;
    logic [DW-1:0] mem [0:255];
    int            n_chk = 0;
    int            n_err = 0;

    mem_arbiter #(.data_size(DW), .mem_size(AW)) dut (
        .clk(clk), .rst(rst),
        .IM_req(IM_req), .IM_Address(IM_Address), .Instruction(Instruction), .IM_ready(IM_ready),
        .DM_read(DM_read), .DM_enable(DM_enable), .DM_Address(DM_Address),
        .DM_Write_Data(DM_Write_Data), .DM_Read_Data(DM_Read_Data), .DM_ready(DM_ready),
        .Stall(Stall), .MEM_req(MEM_req), .MEM_enable(MEM_enable), .MEM_Address(MEM_Address),
        .MEM_Write_Data(MEM_Write_Data), .MEM_Read_Data(mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (MEM_req) begin
            if (MEM_enable)
                mem[MEM_Address[7:0]] <= MEM_Write_Data;
            else
                mem_rd <= mem[MEM_Address[7:0]];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick; settle;
        n_chk++; if (MEM_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %0h exp 0", MEM_req); end
        n_chk++; if (IM_ready !== 1'b0) begin n_err++; $display("FAIL rst_im_ready: got %0h exp 0", IM_ready); end
        n_chk++; if (DM_ready !== 1'b0) begin n_err++; $display("FAIL rst_dm_ready: got %0h exp 0", DM_ready); end
        n_chk++; if (Instruction !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %08h exp 0", Instruction); end
        n_chk++; if (DM_Read_Data !== 32'h0) begin n_err++; $display("FAIL rst_dm_rd: got %08h exp 0", DM_Read_Data); end
        n_chk++; if (Stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %0h exp 0", Stall); end
        IM_req = 1'b1; IM_Address = 16'h0004; DM_read = 1'b1; DM_Address = 16'h0020;
        #1;
        n_chk++; if (MEM_req !== 1'b0) begin n_err++; $display("FAIL rst_suppress_req: got %0h exp 0", MEM_req); end
        n_chk++; if (MEM_Address !== 16'h0) begin n_err++; $display("FAIL rst_suppress_addr: got %04h exp 0", MEM_Address); end
        tick;
        IM_req = 1'b0; DM_read = 1'b0; rst = 1'b0;
        settle;
        n_chk++; if (MEM_req !== 1'b0) begin n_err++; $display("FAIL rst_idle_req: got %0h exp 0", MEM_req); end
        tick;
    endtask

    task automatic test_fetch;
        IM_req = 1'b1; IM_Address = 16'h0004;
        settle;
        n_chk++; if (MEM_req !== 1'b1) begin n_err++; $display("FAIL fetch_req: got %0h exp 1", MEM_req); end
        n_chk++; if (MEM_Address !== 16'h0004) begin n_err++; $display("FAIL fetch_addr: got %04h exp 0004", MEM_Address); end
        n_chk++; if (MEM_enable !== 1'b0) begin n_err++; $display("FAIL fetch_we: got %0h exp 0", MEM_enable); end
        n_chk++; if (Stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall_n: got %0h exp 1", Stall); end
        n_chk++; if (IM_ready !== 1'b0) begin n_err++; $display("FAIL fetch_ready_n: got %0h exp 0", IM_ready); end
        tick; settle;
        n_chk++; if (IM_ready !== 1'b1) begin n_err++; $display("FAIL fetch_ready: got %0h exp 1", IM_ready); end
        n_chk++; if (Instruction !== 32'h8C010008) begin n_err++; $display("FAIL fetch_instr: got %08h exp 8C010008", Instruction); end
        n_chk++; if (Stall !== 1'b0) begin n_err++; $display("FAIL fetch_stall_n1: got %0h exp 0", Stall); end
        n_chk++; if (MEM_req !== 1'b0) begin n_err++; $display("FAIL fetch_no_reissue: got %0h exp 0", MEM_req); end
        tick;
        IM_req = 1'b0;
        settle;
        n_chk++; if (IM_ready !== 1'b0) begin n_err++; $display("FAIL fetch_pulse: got %0h exp 0", IM_ready); end
        n_chk++; if (Instruction !== 32'h8C010008) begin n_err++; $display("FAIL fetch_hold: got %08h exp 8C010008", Instruction); end
        tick;
    endtask

    task automatic test_back_to_back;
        IM_req = 1'b1; IM_Address = 16'h0040; DM_read = 1'b1; DM_Address = 16'h0050;
        settle;
        n_chk++; if (MEM_Address !== 16'h0050) begin n_err++; $display("FAIL b2b_g0: got %04h exp 0050", MEM_Address); end
        n_chk++; if (Stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall0: got %0h exp 1", Stall); end
        tick; settle;
        n_chk++; if (DM_ready !== 1'b1) begin n_err++; $display("FAIL b2b_dready1: got %0h exp 1", DM_ready); end
        n_chk++; if (DM_Read_Data !== 32'hB0B0B0B0) begin n_err++; $display("FAIL b2b_drd1: got %08h exp B0B0B0B0", DM_Read_Data); end
        n_chk++; if (MEM_Address !== 16'h0040) begin n_err++; $display("FAIL b2b_g1: got %04h exp 0040", MEM_Address); end
        tick; settle;
        n_chk++; if (IM_ready !== 1'b1) begin n_err++; $display("FAIL b2b_iready2: got %0h exp 1", IM_ready); end
        n_chk++; if (Instruction !== 32'hA0A0A0A0) begin n_err++; $display("FAIL b2b_instr2: got %08h exp A0A0A0A0", Instruction); end
        n_chk++; if (MEM_Address !== 16'h0050) begin n_err++; $display("FAIL b2b_g2: got %04h exp 0050", MEM_Address); end
        tick; settle;
        n_chk++; if (DM_ready !== 1'b1) begin n_err++; $display("FAIL b2b_dready3: got %0h exp 1", DM_ready); end
        n_chk++; if (MEM_Address !== 16'h0040) begin n_err++; $display("FAIL b2b_g3: got %04h exp 0040", MEM_Address); end
        tick;
        DM_read = 1'b0;
        settle;
        n_chk++; if (IM_ready !== 1'b1) begin n_err++; $display("FAIL b2b_iready4: got %0h exp 1", IM_ready); end
        n_chk++; if (MEM_req !== 1'b0) begin n_err++; $display("FAIL b2b_req4: got %0h exp 0", MEM_req); end
        tick;
        IM_req = 1'b0;
        settle;
        n_chk++; if (Stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall5: got %0h exp 0", Stall); end
        tick;
    endtask

    task automatic test_collision;
        IM_req = 1'b1; IM_Address = 16'h0008; DM_read = 1'b1; DM_Address = 16'h0020;
        settle;
        n_chk++; if (MEM_Address !== 16'h0020) begin n_err++; $display("FAIL col_d_first: got %04h exp 0020", MEM_Address); end
        n_chk++; if (Stall !== 1'b1) begin n_err++; $display("FAIL col_stall_n: got %0h exp 1", Stall); end
        tick; settle;
        n_chk++; if (DM_ready !== 1'b1) begin n_err++; $display("FAIL col_dready: got %0h exp 1", DM_ready); end
        n_chk++; if (DM_Read_Data !== 32'h22222222) begin n_err++; $display("FAIL col_drd: got %08h exp 22222222", DM_Read_Data); end
        n_chk++; if (MEM_Address !== 16'h0008 || MEM_req !== 1'b1) begin n_err++; $display("FAIL col_i_issue: got %04h/%0h exp 0008/1", MEM_Address, MEM_req); end
        n_chk++; if (IM_ready !== 1'b0) begin n_err++; $display("FAIL col_iready_n1: got %0h exp 0", IM_ready); end
        n_chk++; if (Stall !== 1'b1) begin n_err++; $display("FAIL col_stall_n1: got %0h exp 1", Stall); end
        tick;
        DM_read = 1'b0;
        settle;
        n_chk++; if (IM_ready !== 1'b1) begin n_err++; $display("FAIL col_iready: got %0h exp 1", IM_ready); end
        n_chk++; if (Instruction !== 32'h11111111) begin n_err++; $display("FAIL col_instr: got %08h exp 11111111", Instruction); end
        n_chk++; if (Stall !== 1'b0) begin n_err++; $display("FAIL col_stall_n2: got %0h exp 0", Stall); end
        tick;
        IM_req = 1'b0;
        tick;
    endtask

    task automatic test_store_load;
        DM_enable = 1'b1; DM_Address = 16'h0010; DM_Write_Data = 32'hDEADBEEF;
        settle;
        n_chk++; if (MEM_enable !== 1'b1) begin n_err++; $display("FAIL st_we: got %0h exp 1", MEM_enable); end
        n_chk++; if (MEM_Write_Data !== 32'hDEADBEEF) begin n_err++; $display("FAIL st_wdata: got %08h exp DEADBEEF", MEM_Write_Data); end
        n_chk++; if (MEM_Address !== 16'h0010) begin n_err++; $display("FAIL st_addr: got %04h exp 0010", MEM_Address); end
        tick; settle;
        n_chk++; if (DM_ready !== 1'b1) begin n_err++; $display("FAIL st_ready: got %0h exp 1", DM_ready); end
        n_chk++; if (DM_Read_Data !== 32'h22222222) begin n_err++; $display("FAIL st_rd_hold: got %08h exp 22222222", DM_Read_Data); end
        tick;
        DM_enable = 1'b0; DM_read = 1'b1; DM_Write_Data = '0;
        settle;
        n_chk++; if (MEM_req !== 1'b1 || MEM_enable !== 1'b0) begin n_err++; $display("FAIL ld_issue: got req %0h we %0h exp 1/0", MEM_req, MEM_enable); end
        tick; settle;
        n_chk++; if (DM_Read_Data !== 32'hDEADBEEF) begin n_err++; $display("FAIL ld_after_st: got %08h exp DEADBEEF", DM_Read_Data); end
        tick;
        DM_read = 1'b0;
        tick;
    endtask

    task automatic test_rw_both;
        DM_read = 1'b1; DM_Address = 16'h0030;
        tick; settle;
        n_chk++; if (DM_Read_Data !== 32'h12345678) begin n_err++; $display("FAIL rw_preload: got %08h exp 12345678", DM_Read_Data); end
        tick;
        DM_enable = 1'b1; DM_Address = 16'h0031; DM_Write_Data = 32'hCAFEF00D;
        settle;
        n_chk++; if (MEM_enable !== 1'b1 || MEM_Write_Data !== 32'hCAFEF00D) begin n_err++; $display("FAIL rw_write: got we %0h data %08h exp 1/CAFEF00D", MEM_enable, MEM_Write_Data); end
        tick; settle;
        n_chk++; if (DM_ready !== 1'b1) begin n_err++; $display("FAIL rw_ready: got %0h exp 1", DM_ready); end
        n_chk++; if (DM_Read_Data !== 32'h12345678) begin n_err++; $display("FAIL rw_rd_ready: got %08h exp 12345678", DM_Read_Data); end
        tick;
        DM_read = 1'b0; DM_enable = 1'b0; DM_Write_Data = '0;
        settle;
        n_chk++; if (DM_Read_Data !== 32'h12345678) begin n_err++; $display("FAIL rw_rd_after: got %08h exp 12345678", DM_Read_Data); end
        n_chk++; if (mem[8'h31] !== 32'hCAFEF00D) begin n_err++; $display("FAIL rw_mem: got %08h exp CAFEF00D", mem[8'h31]); end
        tick;
    endtask

    task automatic test_reset_mid;
        DM_read = 1'b1; DM_Address = 16'h0010;
        settle;
        n_chk++; if (MEM_req !== 1'b1) begin n_err++; $display("FAIL rm_issue: got %0h exp 1", MEM_req); end
        tick;
        rst = 1'b1;
        settle;
        n_chk++; if (DM_ready !== 1'b0) begin n_err++; $display("FAIL rm_ready: got %0h exp 0", DM_ready); end
        n_chk++; if (DM_Read_Data !== 32'h0) begin n_err++; $display("FAIL rm_rd_clear: got %08h exp 0", DM_Read_Data); end
        n_chk++; if (Instruction !== 32'h0) begin n_err++; $display("FAIL rm_instr_clear: got %08h exp 0", Instruction); end
        n_chk++; if (MEM_req !== 1'b0) begin n_err++; $display("FAIL rm_req_in_rst: got %0h exp 0", MEM_req); end
        tick;
        rst = 1'b0;
        settle;
        n_chk++; if (MEM_req !== 1'b1 || MEM_Address !== 16'h0010) begin n_err++; $display("FAIL rm_first_issue: got %0h/%04h exp 1/0010", MEM_req, MEM_Address); end
        tick; settle;
        n_chk++; if (DM_ready !== 1'b1 || DM_Read_Data !== 32'hDEADBEEF) begin n_err++; $display("FAIL rm_reload: got %0h/%08h exp 1/DEADBEEF", DM_ready, DM_Read_Data); end
        tick;
        DM_read = 1'b0;
        tick;
    endtask

    task automatic dual(input string tag, input bit d_first);
        IM_req = 1'b1; IM_Address = 16'h0008; DM_read = 1'b1; DM_Address = 16'h0020;
        settle;
        n_chk++; if (MEM_Address !== (d_first ? 16'h0020 : 16'h0008)) begin n_err++; $display("FAIL %s_winner: got %04h exp %04h", tag, MEM_Address, d_first ? 16'h0020 : 16'h0008); end
        tick; settle;
        n_chk++; if (DM_ready !== d_first || IM_ready !== ~d_first) begin n_err++; $display("FAIL %s_ready1: got d %0h i %0h exp d %0h", tag, DM_ready, IM_ready, d_first); end
        tick;
        if (d_first) DM_read = 1'b0; else IM_req = 1'b0;
        settle;
        n_chk++; if (DM_ready !== ~d_first || IM_ready !== d_first) begin n_err++; $display("FAIL %s_ready2: got d %0h i %0h exp d %0h", tag, DM_ready, IM_ready, ~d_first); end
        tick;
        IM_req = 1'b0; DM_read = 1'b0;
        tick;
    endtask

    task automatic test_priority;
        IM_req = 1'b1; IM_Address = 16'h0008;
        tick; tick;
        IM_req = 1'b0;
        tick;
        dual("pri_i_last", 1'b1);
        DM_read = 1'b1; DM_Address = 16'h0020;
        tick; tick;
        DM_read = 1'b0;
        tick;
        dual("pri_d_last", !RR);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= '0;
        mem[8'h04] <= 32'h8C010008;
        mem[8'h08] <= 32'h11111111;
        mem[8'h20] <= 32'h22222222;
        mem[8'h30] <= 32'h12345678;
        mem[8'h40] <= 32'hA0A0A0A0;
        mem[8'h50] <= 32'hB0B0B0B0;
        test_reset;
        test_fetch;
        test_back_to_back;
        test_collision;
        test_store_load;
        test_rw_both;
        test_reset_mid;
        test_priority;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not end by 50000 exp earlier");
        $fatal(1);
    end
endmodule
